// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencer: state encoding and
// derived widths/latencies.
package sa_pkg;

  typedef enum logic [2:0] {
    st_idle,
    st_load_w,
    st_feed,
    st_drain,
    st_done
  } sa_state_e;

  // Default fill/drain latency of an n x n array.
  function automatic int sa_lat(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int sa_row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_controller_if.sv
// Buffer/array side of the sequencer: weight, activation and result buffer
// strobes plus the array weight-latch and activation-valid signals.
interface sa_controller_if
  import sa_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 8
);
  localparam int ROW_W = sa_row_w(N);

  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_load;
  logic [ROW_W-1:0]  w_row;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic              a_valid;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;

  modport master (
    output w_rd_en, w_rd_addr, w_load, w_row,
    output a_rd_en, a_rd_addr, a_valid,
    output o_wr_en, o_wr_addr
  );

  modport slave (
    input w_rd_en, w_rd_addr, w_load, w_row,
    input a_rd_en, a_rd_addr, a_valid,
    input o_wr_en, o_wr_addr
  );
endinterface

// File: rtl/sa_delay_line.sv
// Fixed-depth valid delay matching the array fill/drain latency; flush drops
// every in-flight token at once.
module sa_delay_line #(
  parameter int DEPTH = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | DEPTH'(din);
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sa_controller.sv
// Job sequencer for an N x N weight-stationary systolic array: loads weights,
// streams M activation rows, and writes results as they drain out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// st_idle   | waiting for start; configuration captured on accept
// st_load_w | N weight-buffer reads, one array row latched per cycle
// st_feed   | M activation-buffer reads streamed into the array
// st_drain  | waiting for the last result write to leave the array
// st_done   | one-cycle completion pulse
module sa_controller
  import sa_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 8,
  parameter int LAT    = sa_lat(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] m_len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] o_base,
  sa_controller_if.master   buf_if,
  output logic              busy,
  output logic              done
);

  localparam int              ROW_W    = sa_row_w(N);
  localparam logic [ADDR_W-1:0] CNT_LOAD = ADDR_W'(N - 1);

  sa_state_e state, state_nxt;

  logic [ADDR_W-1:0] m_r;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] o_addr;
  logic [ADDR_W-1:0] o_cnt;
  logic [ROW_W-1:0]  wk;
  logic [ROW_W-1:0]  w_row_r;
  logic              w_load_r;
  logic              a_valid_r;
  logic              o_wr_en_d;
  logic              accept;
  logic              abort_act;
  logic              w_rd_en;
  logic              a_rd_en;
  logic              cnt_tc;

  assign accept    = (state == st_idle) && start && !abort;
  assign abort_act = (state != st_idle) && abort;
  assign w_rd_en   = (state == st_load_w);
  assign a_rd_en   = (state == st_feed);
  assign cnt_tc    = (cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:   if (accept) state_nxt = st_load_w;
      st_load_w: if (cnt_tc) state_nxt = (m_r == '0) ? st_done : st_feed;
      st_feed:   if (cnt_tc) state_nxt = st_drain;
      st_drain:  if (o_wr_en_d && (o_cnt == '0)) state_nxt = st_done;
      st_done:   state_nxt = st_idle;
      default:   state_nxt = st_idle;
    endcase
    if (abort_act) state_nxt = st_idle;
  end

  // cnt is shared: it times LOAD_W, then is reloaded with M-1 to time FEED.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_r       <= '0;
      cnt       <= '0;
      w_addr    <= '0;
      a_addr    <= '0;
      o_addr    <= '0;
      o_cnt     <= '0;
      wk        <= '0;
      w_row_r   <= '0;
      w_load_r  <= 1'b0;
      a_valid_r <= 1'b0;
    end else begin
      w_load_r  <= w_rd_en && !abort_act;
      w_row_r   <= w_rd_en ? wk : '0;
      a_valid_r <= a_rd_en && !abort_act;
      if (accept) begin
        m_r    <= m_len;
        cnt    <= CNT_LOAD;
        w_addr <= w_base;
        a_addr <= a_base;
        o_addr <= o_base;
        o_cnt  <= m_len - 1'b1;
        wk     <= '0;
      end else begin
        if (w_rd_en) begin
          w_addr <= w_addr + 1'b1;
          wk     <= wk + 1'b1;
          cnt    <= cnt_tc ? (m_r - 1'b1) : (cnt - 1'b1);
        end
        if (a_rd_en) begin
          a_addr <= a_addr + 1'b1;
          cnt    <= cnt - 1'b1;
        end
        if (o_wr_en_d) begin
          o_addr <= o_addr + 1'b1;
          o_cnt  <= o_cnt - 1'b1;
        end
      end
    end
  end

  sa_delay_line #(
    .DEPTH(LAT)
  ) u_dly (
    .clock(clock),
    .reset(reset),
    .flush(abort_act),
    .din  (a_valid_r),
    .dout (o_wr_en_d)
  );

  assign buf_if.w_rd_en   = w_rd_en;
  assign buf_if.w_rd_addr = w_rd_en ? w_addr : '0;
  assign buf_if.w_load    = w_load_r;
  assign buf_if.w_row     = w_row_r;
  assign buf_if.a_rd_en   = a_rd_en;
  assign buf_if.a_rd_addr = a_rd_en ? a_addr : '0;
  assign buf_if.a_valid   = a_valid_r;
  assign buf_if.o_wr_en   = o_wr_en_d;
  assign buf_if.o_wr_addr = o_wr_en_d ? o_addr : '0;

  assign busy = (state != st_idle);
  assign done = (state == st_done) && !abort;

endmodule

// File: tb/tb_sa_controller.sv
// Bench for sa_controller: vector table of whole jobs, randomized jobs against
// a timeline model, and hand sequences for abort, reset and start/abort in idle.
module tb_sa_controller;

  localparam int N      = 4;
  localparam int ADDR_W = 8;
  localparam int LAT    = 2 * N - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] m_len  = '0;
  logic [ADDR_W-1:0] w_base = '0;
  logic [ADDR_W-1:0] a_base = '0;
  logic [ADDR_W-1:0] o_base = '0;
  logic              busy;
  logic              done;

  sa_controller_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  sa_controller #(.N(N), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .abort (abort),
    .m_len (m_len),
    .w_base(w_base),
    .a_base(a_base),
    .o_base(o_base),
    .buf_if(bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       w_rd_en;
    logic [7:0] w_rd_addr;
    logic       w_load;
    logic [1:0] w_row;
    logic       a_rd_en;
    logic [7:0] a_rd_addr;
    logic       a_valid;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int m, wb, ab, ob, poke;
    int exp_busy, exp_ocnt, exp_last_w, exp_last_a, exp_last_o;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[6];

  // Expected outputs in cycle c after start was accepted (c = 1 is the first busy cycle).
  function automatic obs_t model(int c, int m, int wb, int ab, int ob);
    obs_t e;
    int   fin;
    e   = '0;
    fin = (m == 0) ? N + 1 : N + m + LAT + 2;
    e.w_rd_en   = (c >= 1 && c <= N);
    e.w_rd_addr = 8'(wb + c - 1);
    e.w_load    = (c >= 2 && c <= N + 1);
    e.w_row     = 2'(c - 2);
    e.a_rd_en   = (m > 0 && c >= N + 1 && c <= N + m);
    e.a_rd_addr = 8'(ab + c - N - 1);
    e.a_valid   = (m > 0 && c >= N + 2 && c <= N + m + 1);
    e.o_wr_en   = (m > 0 && c >= N + LAT + 2 && c <= N + m + LAT + 1);
    e.o_wr_addr = 8'(ob + c - N - LAT - 2);
    e.busy      = (c >= 1 && c <= fin);
    e.done      = (c == fin);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.w_rd_en   = bus.w_rd_en;
    a.w_rd_addr = bus.w_rd_addr;
    a.w_load    = bus.w_load;
    a.w_row     = bus.w_row;
    a.a_rd_en   = bus.a_rd_en;
    a.a_rd_addr = bus.a_rd_addr;
    a.a_valid   = bus.a_valid;
    a.o_wr_en   = bus.o_wr_en;
    a.o_wr_addr = bus.o_wr_addr;
    a.busy      = busy;
    a.done      = done;
    return a;
  endfunction

  // Addresses/row are only meaningful alongside their strobe unless strict.
  task automatic check_obs(string tag, obs_t e, bit strict);
    obs_t a;
    a = sample();
    if (!strict) begin
      if (!e.w_rd_en) a.w_rd_addr = e.w_rd_addr;
      if (!e.w_load)  a.w_row     = e.w_row;
      if (!e.a_rd_en) a.a_rd_addr = e.a_rd_addr;
      if (!e.o_wr_en) a.o_wr_addr = e.o_wr_addr;
    end
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, a, e);
  endtask

  task automatic check_int(string tag, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // poke: 0 none, 1 start pulses through FEED, 2 random start pulses while busy.
  task automatic run_job(input int m, input int wb, input int ab, input int ob,
                         input int poke, output int busy_cnt, output int ocnt,
                         output int last_w, output int last_a, output int last_o);
    int fin;
    busy_cnt = 0; ocnt = 0; last_w = 0; last_a = 0; last_o = 0;
    fin = (m == 0) ? N + 1 : N + m + LAT + 2;
    @(negedge clock);
    m_len = 8'(m); w_base = 8'(wb); a_base = 8'(ab); o_base = 8'(ob);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= fin + 2; c++) begin
      if (c > 1) @(negedge clock);
      check_obs($sformatf("job m=%0d c%0d", m, c), model(c, m, wb, ab, ob), 1'b0);
      if (busy) busy_cnt++;
      if (bus.w_rd_en) last_w = int'(bus.w_rd_addr);
      if (bus.a_rd_en) last_a = int'(bus.a_rd_addr);
      if (bus.o_wr_en) begin
        ocnt++;
        last_o = int'(bus.o_wr_addr);
      end
      start = 1'b0;
      if (c <= fin) begin
        if ((poke == 1 && c >= N + 1 && c <= N + m) ||
            (poke == 2 && $urandom_range(0, 3) == 0)) begin
          start  = 1'b1;
          m_len  = 8'($urandom);
          w_base = 8'($urandom);
          a_base = 8'($urandom);
          o_base = 8'($urandom);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int bc, oc, lw, la, lo, m;

    tbl[0] = '{3,  'h00, 'h10, 'h20, 0, 16, 3,  'h03, 'h12, 'h22};
    tbl[1] = '{0,  'h05, 'h00, 'h00, 0, 5,  0,  'h08, 0,    0};
    tbl[2] = '{1,  'hFE, 'hFF, 'hFF, 0, 14, 1,  'h01, 'hFF, 'hFF};
    tbl[3] = '{5,  'h40, 'h30, 'hFE, 0, 18, 5,  'h43, 'h34, 'h02};
    tbl[4] = '{10, 'h80, 'hF8, 'h00, 2, 23, 10, 'h83, 'h01, 'h09};
    tbl[5] = '{3,  'h00, 'h10, 'h20, 1, 16, 3,  'h03, 'h12, 'h22};

    #2 reset = 1'b0;
    #1 check_obs("reset outputs", '0, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_obs("idle after reset", '0, 1'b1);

    foreach (tbl[i]) begin
      run_job(tbl[i].m, tbl[i].wb, tbl[i].ab, tbl[i].ob, tbl[i].poke, bc, oc, lw, la, lo);
      check_int($sformatf("vec%0d busy cycles", i), bc, tbl[i].exp_busy);
      check_int($sformatf("vec%0d o_wr count", i), oc, tbl[i].exp_ocnt);
      check_int($sformatf("vec%0d last w addr", i), lw, tbl[i].exp_last_w);
      if (tbl[i].m > 0) begin
        check_int($sformatf("vec%0d last a addr", i), la, tbl[i].exp_last_a);
        check_int($sformatf("vec%0d last o addr", i), lo, tbl[i].exp_last_o);
      end
    end

    // Start and abort together in idle: nothing happens.
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_obs("start+abort idle", '0, 1'b0);
      @(negedge clock);
    end

    // Abort during DRAIN: no result writes, no done.
    m_len = 8'd3; w_base = 8'h00; a_base = 8'h10; o_base = 8'h20;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clock);
      check_obs($sformatf("abort pre c%0d", c), model(c, 3, 'h00, 'h10, 'h20), 1'b0);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    for (int c = 11; c <= 26; c++) begin
      check_obs($sformatf("abort quiet c%0d", c), '0, 1'b0);
      @(negedge clock);
    end
    run_job(3, 'h00, 'h10, 'h20, 0, bc, oc, lw, la, lo);
    check_int("post-abort o_wr count", oc, 3);
    check_int("post-abort busy cycles", bc, 16);

    // Reset mid-job in cycle 6.
    m_len = 8'd3; w_base = 8'h00; a_base = 8'h10; o_base = 8'h20;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1 check_obs("reset mid-job", '0, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check_obs($sformatf("after reset c%0d", c), '0, 1'b1);
    end
    run_job(3, 'h00, 'h10, 'h20, 0, bc, oc, lw, la, lo);
    check_int("post-reset o_wr count", oc, 3);

    for (int i = 0; i < 25; i++) begin
      m = int'($urandom_range(0, 12));
      run_job(m, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 2, bc, oc, lw, la, lo);
      check_int($sformatf("rand%0d o_wr count", i), oc, m);
    end

    // Largest job length.
    run_job(255, 'hFE, 'h80, 'h01, 0, bc, oc, lw, la, lo);
    check_int("m255 o_wr count", oc, 255);
    check_int("m255 busy cycles", bc, N + 255 + LAT + 2);
    check_int("m255 last a addr", la, 'h7E);
    check_int("m255 last o addr", lo, 'h FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
